// File: rtl/sd_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg -- shared definitions for the SD command transmitter (sd_cmd_tx).
//   * FSM state encoding for the command transmitter.
//   * 48-bit SD command frame geometry and the fixed framing bits.
//   * CRC7 operand width (the engine only ever sees the 32-bit argument).
//   * sd_build_frame(): assembles {start, tx, index, arg, crc7, end}.
// No ports (package).
// ---------------------------------------------------------------------------
package sd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CRC_REQ  = 3'd1,
      ST_CRC_WAIT = 3'd2,
      ST_LOAD     = 3'd3,
      ST_SHIFT    = 3'd4,
      ST_FIN      = 3'd5
   } sd_state_e;

   localparam int   SD_FRAME_W    = 48;
   localparam logic SD_START_BIT  = 1'b0;
   localparam logic SD_TX_BIT     = 1'b1;
   localparam logic SD_END_BIT    = 1'b1;
   localparam int   SD_CRC_OPND_W = 32;
   localparam int   SD_BIT_CNT_W  = 6;

   // Command frame, MSB first on the wire.
   function automatic logic [SD_FRAME_W-1:0] sd_build_frame(
      input logic [5:0]               idx,
      input logic [SD_CRC_OPND_W-1:0] arg,
      input logic [6:0]               crc
   );
      return {SD_START_BIT, SD_TX_BIT, idx, arg, crc, SD_END_BIT};
   endfunction

endpackage

// File: rtl/sd_sclk_gen.sv
// ---------------------------------------------------------------------------
// sd_sclk_gen -- sclk half-period divider for the SD command transmitter.
// While en is high it counts CLK_DIV clk cycles per sclk half period and
// emits a one-cycle strobe at the end of each half period: rise_en when the
// tracked sclk level is low, fall_en when it is high. The tracked level
// starts low, so the first strobe is always a rise. Deasserting en clears
// the count and the tracked level.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   en      in   divider enable (high only while shifting)
//   rise_en out  one-cycle strobe: sclk should go high on the next edge
//   fall_en out  one-cycle strobe: sclk should go low on the next edge
// ---------------------------------------------------------------------------
module sd_sclk_gen
   import sd_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic rise_en,
   output logic fall_en
);

   logic [7:0] div_cnt_r;
   logic       level_r;
   logic       term_s;

   assign term_s  = en && (div_cnt_r == 8'(CLK_DIV - 1));
   assign rise_en = term_s && !level_r;
   assign fall_en = term_s &&  level_r;

   // Half-period counter and tracked sclk level.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_r <= 8'd0;
         level_r   <= 1'b0;
      end else if (!en) begin
         div_cnt_r <= 8'd0;
         level_r   <= 1'b0;
      end else if (term_s) begin
         div_cnt_r <= 8'd0;
         level_r   <= !level_r;
      end else begin
         div_cnt_r <= div_cnt_r + 8'd1;
      end
   end

endmodule

// File: rtl/sd_cmd_tx.sv
// ---------------------------------------------------------------------------
// sd_cmd_tx -- SD (SPI mode 0) command frame transmitter.
// Accepts a command index/argument, asks an external CRC7 engine for the
// checksum, then shifts the 48-bit frame {0,1,index,arg,crc7,1} out MSB
// first on mosi with cs_n low. mosi changes on falling sclk edges so it is
// stable at every rising edge.
//
// Build option: define SD_CMD_TX_CRC_TIMEOUT_EN to abort the CRC wait after
// TIMEOUT clk cycles without crc_done (err pulses, no frame is sent).
// Without it, the CRC wait is unbounded and err is constant 0.
//
// Parameters:
//   CLK_DIV  clk cycles per sclk half period (1..255)
//   TIMEOUT  CRC wait limit in clk cycles (only with the timeout build)
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command request
//   cmd_ready  out  idle and accepting a command
//   cmd_index  in   [5:0]  SD command index
//   cmd_arg    in   [31:0] command argument
//   crc_start  out  one-cycle start pulse to the CRC7 engine
//   crc_data   out  [31:0] CRC engine operand (captured argument)
//   crc_result in   [7:0]  CRC engine remainder, bits [6:0] used
//   crc_done   in   CRC engine completion pulse
//   sclk       out  SPI clock (idles low)
//   mosi       out  SPI data (idles high)
//   cs_n       out  SPI chip select, active low
//   done       out  one-cycle pulse after a complete frame
//   err        out  one-cycle pulse on CRC timeout
// ---------------------------------------------------------------------------
module sd_cmd_tx
   import sd_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   output logic        crc_start,
   output logic [31:0] crc_data,
   input  logic [7:0]  crc_result,
   input  logic        crc_done,
   output logic        sclk,
   output logic        mosi,
   output logic        cs_n,
   output logic        done,
   output logic        err
);

   generate
      if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
         $error("sd_cmd_tx: CLK_DIV must be within 1..255");
      end
      if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
         $error("sd_cmd_tx: TIMEOUT must be within 1..65535");
      end
   endgenerate

   sd_state_e                 state_r;
   sd_state_e                 next_state_s;
   logic [5:0]                idx_r;
   logic [SD_CRC_OPND_W-1:0]  arg_r;
   logic [6:0]                crc_r;
   logic [SD_FRAME_W-1:0]     shreg_r;
   logic [SD_BIT_CNT_W-1:0]   bit_cnt_r;
   logic                      cmd_ready_r;
   logic                      crc_start_r;
   logic                      cs_n_r;
   logic                      sclk_r;
   logic                      mosi_r;
   logic                      done_r;
   logic                      accept_s;
   logic                      shift_en_s;
   logic                      rise_s;
   logic                      fall_s;
   logic                      last_fall_s;
   logic                      timeout_s;
   logic                      unused_s;

   // Bit 7 of the CRC remainder carries no information for CRC7.
   assign unused_s = crc_result[7];

   assign accept_s    = cmd_valid && cmd_ready_r;
   assign shift_en_s  = (state_r == ST_SHIFT);
   assign last_fall_s = fall_s && (bit_cnt_r == 6'd47);

   assign cmd_ready = cmd_ready_r;
   assign crc_start = crc_start_r;
   assign crc_data  = arg_r;
   assign sclk      = sclk_r;
   assign mosi      = mosi_r;
   assign cs_n      = cs_n_r;
   assign done      = done_r;

   sd_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk     (clk),
      .rst     (rst),
      .en      (shift_en_s),
      .rise_en (rise_s),
      .fall_en (fall_s)
   );

`ifdef SD_CMD_TX_CRC_TIMEOUT_EN
   logic [15:0] to_cnt_r;
   logic        err_r;

   // Counts consecutive CRC_WAIT cycles without crc_done.
   assign timeout_s = (state_r == ST_CRC_WAIT) && !crc_done &&
                      (to_cnt_r == 16'(TIMEOUT - 1));
   assign err       = err_r;

   // CRC wait timeout counter and its error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_r <= 16'd0;
         err_r    <= 1'b0;
      end else begin
         err_r <= timeout_s;
         if (state_r == ST_CRC_WAIT && !crc_done) begin
            to_cnt_r <= to_cnt_r + 16'd1;
         end else begin
            to_cnt_r <= 16'd0;
         end
      end
   end
`else
   assign timeout_s = 1'b0;
   assign err       = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_state_s = ST_CRC_REQ;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_CRC_REQ: begin
            next_state_s = ST_CRC_WAIT;
         end
         ST_CRC_WAIT: begin
            // A completion arriving on the timeout cycle still wins.
            if (crc_done) begin
               next_state_s = ST_LOAD;
            end else if (timeout_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_CRC_WAIT;
            end
         end
         ST_LOAD: begin
            next_state_s = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (last_fall_s) begin
               next_state_s = ST_FIN;
            end else begin
               next_state_s = ST_SHIFT;
            end
         end
         ST_FIN: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Datapath and registered outputs. Strobes and cs_n are derived from the
   // next state so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r       <= 6'd0;
         arg_r       <= 32'd0;
         crc_r       <= 7'd0;
         shreg_r     <= 48'd0;
         bit_cnt_r   <= 6'd0;
         cmd_ready_r <= 1'b0;
         crc_start_r <= 1'b0;
         cs_n_r      <= 1'b1;
         sclk_r      <= 1'b0;
         mosi_r      <= 1'b1;
         done_r      <= 1'b0;
      end else begin
         cmd_ready_r <= (next_state_s == ST_IDLE);
         crc_start_r <= (next_state_s == ST_CRC_REQ);
         done_r      <= (next_state_s == ST_FIN);
         cs_n_r      <= !((next_state_s == ST_LOAD) || (next_state_s == ST_SHIFT));
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  idx_r <= cmd_index;
                  arg_r <= cmd_arg;
               end
            end
            ST_CRC_WAIT: begin
               if (crc_done) begin
                  crc_r  <= crc_result[6:0];
                  // Frame bit 47 is the constant start bit.
                  mosi_r <= SD_START_BIT;
               end
            end
            ST_LOAD: begin
               shreg_r   <= sd_build_frame(idx_r, arg_r, crc_r);
               bit_cnt_r <= 6'd0;
            end
            ST_SHIFT: begin
               if (rise_s) begin
                  sclk_r <= 1'b1;
               end else if (fall_s) begin
                  sclk_r    <= 1'b0;
                  shreg_r   <= {shreg_r[SD_FRAME_W-2:0], 1'b0};
                  bit_cnt_r <= bit_cnt_r + 6'd1;
                  // After the last bit the line returns to its idle-high level.
                  if (last_fall_s) begin
                     mosi_r <= 1'b1;
                  end else begin
                     mosi_r <= shreg_r[SD_FRAME_W-2];
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_tx -- self-checking bench for sd_cmd_tx.
// Three instances (CLK_DIV = 2, 1, 4) share clk/rst/index/arg; each has its
// own cmd_valid. A CRC engine model answers crc_start after a programmable
// latency with the true CRC7 of the command. A line monitor rebuilds each
// frame from mosi at rising sclk edges and measures cs_n/sclk behaviour.
// ---------------------------------------------------------------------------
module tb_sd_cmd_tx;

   localparam int N       = 3;
   localparam int TIMEOUT = 255;

   function automatic int div_of(input int g);
      case (g)
         0:       return 2;
         1:       return 1;
         default: return 4;
      endcase
   endfunction

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    cmd_valid = '0;
   logic [N-1:0]    cmd_ready, crc_start, sclk, mosi, cs_n, done, err;
   logic [N-1:0]    crc_done = '0;
   logic [5:0]      cmd_index = 6'd0;
   logic [31:0]     cmd_arg = 32'd0;
   logic [8*N-1:0]  crc_result = '0;
   logic [32*N-1:0] crc_data;

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         sd_cmd_tx #(.CLK_DIV(div_of(g)), .TIMEOUT(TIMEOUT)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .cmd_valid  (cmd_valid[g]),
            .cmd_ready  (cmd_ready[g]),
            .cmd_index  (cmd_index),
            .cmd_arg    (cmd_arg),
            .crc_start  (crc_start[g]),
            .crc_data   (crc_data[g*32 +: 32]),
            .crc_result (crc_result[g*8 +: 8]),
            .crc_done   (crc_done[g]),
            .sclk       (sclk[g]),
            .mosi       (mosi[g]),
            .cs_n       (cs_n[g]),
            .done       (done[g]),
            .err        (err[g])
         );
      end
   endgenerate

   int tests = 0;
   int fails = 0;

   // CRC7 (x^7 + x^3 + 1) over the first 40 frame bits.
   function automatic logic [6:0] crc7_of(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] msg;
      logic [6:0]  c;
      logic        fb;
      msg = {2'b01, idx, arg};
      c   = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb = msg[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] exp_frame(input logic [5:0] idx, input logic [31:0] arg);
      return {2'b01, idx, arg, crc7_of(idx, arg), 1'b1};
   endfunction

   // ---------------- CRC engine model ----------------
   int          crc_lat  = 10;
   logic        crc_mute = 1'b0;
   int          crc_cnt   [N] = '{default: 0};
   int          start_cnt [N] = '{default: 0};
   logic [31:0] seen_data [N] = '{default: 32'd0};
   logic [5:0]  idx_q     [N] = '{default: 6'd0};

   always @(negedge clk) begin
      for (int g = 0; g < N; g++) begin
         crc_done[g] = 1'b0;
         if (rst) begin
            crc_cnt[g] = 0;
         end else if (crc_start[g]) begin
            start_cnt[g]++;
            seen_data[g] = crc_data[g*32 +: 32];
            crc_cnt[g]   = crc_mute ? 0 : crc_lat;
         end else if (crc_cnt[g] > 0) begin
            crc_cnt[g]--;
            if (crc_cnt[g] == 0) begin
               crc_done[g] = 1'b1;
               // bit 7 set on purpose: it must be ignored
               crc_result[g*8 +: 8] = {1'b1, crc7_of(idx_q[g], seen_data[g])};
            end
         end
      end
   end

   // ---------------- line monitor ----------------
   int          rise_cnt  [N] = '{default: 0};
   int          low_cnt   [N] = '{default: 0};
   int          done_cnt  [N] = '{default: 0};
   int          err_cnt   [N] = '{default: 0};
   int          unstable  [N] = '{default: 0};
   int          idle_sclk [N] = '{default: 0};
   int          cs_fall   [N] = '{default: 0};
   int          last_rise [N] = '{default: 0};
   int          last_low  [N] = '{default: 0};
   logic [47:0] frame_q   [N] = '{default: 48'd0};
   logic [47:0] last_frame[N] = '{default: 48'd0};
   logic        prev_sclk [N] = '{default: 1'b0};
   logic        prev_mosi [N] = '{default: 1'b1};
   logic        prev_cs   [N] = '{default: 1'b1};

   always @(negedge clk) begin
      for (int g = 0; g < N; g++) begin
         if (done[g] === 1'b1) done_cnt[g]++;
         if (err[g] === 1'b1)  err_cnt[g]++;
         if (rst) begin
            rise_cnt[g] = 0;
            low_cnt[g]  = 0;
            frame_q[g]  = 48'd0;
         end else if (cs_n[g] === 1'b0) begin
            if (prev_cs[g]) cs_fall[g]++;
            low_cnt[g]++;
            if (sclk[g] && !prev_sclk[g]) begin
               rise_cnt[g]++;
               frame_q[g] = {frame_q[g][46:0], mosi[g]};
               if (mosi[g] !== prev_mosi[g]) unstable[g]++;
            end
         end else begin
            if (sclk[g] !== 1'b0) idle_sclk[g]++;
            if (!prev_cs[g]) begin
               last_frame[g] = frame_q[g];
               last_rise[g]  = rise_cnt[g];
               last_low[g]   = low_cnt[g];
               rise_cnt[g]   = 0;
               low_cnt[g]    = 0;
               frame_q[g]    = 48'd0;
            end
         end
         prev_sclk[g] = sclk[g];
         prev_mosi[g] = mosi[g];
         prev_cs[g]   = cs_n[g];
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input int k);
      int t;
      t = 0;
      while (cmd_ready[k] !== 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("ready_before_cmd", 64'(cmd_ready[k]), 64'd1);
   endtask

   task automatic wait_done(input int k, input int budget);
      int t;
      t = 0;
      while (done[k] !== 1'b1 && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", 64'(done[k]), 64'd1);
   endtask

   // Checks the frame just finished on instance k against the reference.
   task automatic check_frame(input int k, input logic [5:0] idx, input logic [31:0] arg,
                              input int d0, input int s0);
      chk("frame_bits",   64'(last_frame[k]), 64'(exp_frame(idx, arg)));
      chk("sclk_rises",   64'(last_rise[k]), 64'd48);
      // cs_n low for the single LOAD cycle plus 96*CLK_DIV shift cycles
      chk("cs_low_cycles", 64'(last_low[k]), 64'(96 * div_of(k) + 1));
      chk("done_once",    64'(done_cnt[k]), 64'(d0 + 1));
      chk("done_width",   64'(done[k]), 64'd0);
      chk("crc_starts",   64'(start_cnt[k]), 64'(s0 + 1));
      chk("crc_operand",  64'(seen_data[k]), 64'(arg));
      chk("mosi_stable",  64'(unstable[k]), 64'd0);
      chk("sclk_idle_low", 64'(idle_sclk[k]), 64'd0);
      chk("ready_after",  64'(cmd_ready[k]), 64'd1);
      chk("idle_cs_n",    64'(cs_n[k]), 64'd1);
      chk("idle_mosi",    64'(mosi[k]), 64'd1);
   endtask

   task automatic send(input int k, input logic [5:0] idx, input logic [31:0] arg, input int lat);
      int d0, s0;
      d0 = done_cnt[k];
      s0 = start_cnt[k];
      crc_lat  = lat;
      idx_q[k] = idx;
      wait_ready(k);
      cmd_index    = idx;
      cmd_arg      = arg;
      cmd_valid[k] = 1'b1;
      @(negedge clk);
      cmd_valid[k] = 1'b0;
      wait_done(k, 200 + lat + 96 * div_of(k));
      @(negedge clk);
      check_frame(k, idx, arg, d0, s0);
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      logic [5:0]  ia, ib;
      logic [31:0] aa, ab;
      int          d0, s0, t;

      // ---- reset state ----
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < N; k++) begin
         chk("rst_cmd_ready", 64'(cmd_ready[k]), 64'd0);
         chk("rst_cs_n",      64'(cs_n[k]), 64'd1);
         chk("rst_sclk",      64'(sclk[k]), 64'd0);
         chk("rst_mosi",      64'(mosi[k]), 64'd1);
         chk("rst_crc_start", 64'(crc_start[k]), 64'd0);
         chk("rst_done",      64'(done[k]), 64'd0);
         chk("rst_err",       64'(err[k]), 64'd0);
         chk("rst_crc_data",  64'(crc_data[k*32 +: 32]), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 64'(cmd_ready), 64'(3'b111));

      // ---- directed: CMD0 and CMD8 ----
      send(0, 6'd0, 32'h0000_0000, 10);
      chk("cmd0_bytes", 64'(last_frame[0]), 64'h0000_4000_0000_0095);
      send(0, 6'd8, 32'h0000_01AA, 10);
      chk("cmd8_bytes", 64'(last_frame[0]), 64'h0000_4800_0001_AA87);

      // ---- CLK_DIV = 1 and 4 ----
      send(1, 6'(($urandom_range(0, 63))), $urandom, int'($urandom_range(1, 20)));
      send(2, 6'(($urandom_range(0, 63))), $urandom, int'($urandom_range(1, 20)));

      // ---- randomized commands across all instances ----
      for (int i = 0; i < 8; i++) begin
         send(i % N, 6'($urandom_range(0, 63)), $urandom, int'($urandom_range(1, 20)));
      end

      // ---- cmd_valid held high across a frame ----
      ia = 6'($urandom_range(0, 63)); aa = $urandom;
      ib = 6'($urandom_range(0, 63)); ab = $urandom;
      d0 = done_cnt[0];
      s0 = start_cnt[0];
      crc_lat  = 7;
      idx_q[0] = ia;
      wait_ready(0);
      cmd_index = ia; cmd_arg = aa; cmd_valid[0] = 1'b1;
      @(negedge clk);
      cmd_index = ib; cmd_arg = ab;
      wait_done(0, 400);
      chk("held_no_restart", 64'(start_cnt[0]), 64'(s0 + 1));
      idx_q[0] = ib;
      @(negedge clk);
      check_frame(0, ia, aa, d0, s0);
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      chk("held_second_taken", 64'(cmd_ready[0]), 64'd0);
      wait_done(0, 400);
      @(negedge clk);
      check_frame(0, ib, ab, d0 + 1, s0 + 1);

      // ---- reset in the middle of SHIFT ----
      crc_lat  = 5;
      ia       = 6'($urandom_range(0, 63));
      idx_q[0] = ia;
      wait_ready(0);
      cmd_index = ia; cmd_arg = $urandom; cmd_valid[0] = 1'b1;
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      t = 0;
      while (rise_cnt[0] < 20 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("reached_bit20", 64'(rise_cnt[0]), 64'd20);
      d0  = done_cnt[0];
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_cs_n",      64'(cs_n[0]), 64'd1);
      chk("midrst_sclk",      64'(sclk[0]), 64'd0);
      chk("midrst_mosi",      64'(mosi[0]), 64'd1);
      chk("midrst_done",      64'(done[0]), 64'd0);
      chk("midrst_cmd_ready", 64'(cmd_ready[0]), 64'd0);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      chk("midrst_no_done", 64'(done_cnt[0]), 64'(d0));
      chk("midrst_ready",   64'(cmd_ready[0]), 64'd1);
      send(0, 6'd0, 32'h0000_0000, 10);
      chk("post_rst_cmd0", 64'(last_frame[0]), 64'h0000_4000_0000_0095);

`ifdef SD_CMD_TX_CRC_TIMEOUT_EN
      // ---- CRC engine never answers ----
      crc_mute = 1'b1;
      d0 = cs_fall[0];
      wait_ready(0);
      cmd_index = 6'd1; cmd_arg = 32'd0; cmd_valid[0] = 1'b1;
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      t = 0;
      while (err[0] !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      // crc_start was seen on the first negedge above; err follows after
      // TIMEOUT full CRC_WAIT cycles.
      chk("timeout_latency", 64'(t), 64'(TIMEOUT + 1));
      chk("timeout_ready",   64'(cmd_ready[0]), 64'd1);
      chk("timeout_no_cs",   64'(cs_fall[0]), 64'(d0));
      @(negedge clk);
      chk("timeout_err_width", 64'(err[0]), 64'd0);
      crc_mute = 1'b0;
`else
      chk("err_never", 64'(err_cnt[0] + err_cnt[1] + err_cnt[2]), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sd_cmd_tx.md
SD_CMD_TX -- requirements
Module: sd_cmd_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per sclk half-period; legal range 1..255, with an elaboration-time check.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the clk-cycle limit for crc_done; used only under REQ-021.
REQ-003 SHALL have port clk, input, 1, system clock; reset rst, synchronous, active-high.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1, command request.
REQ-006 SHALL have port cmd_ready, output, 1, block idle and accepting.
REQ-007 SHALL have port cmd_index, input, 6, SD command index.
REQ-008 SHALL have port cmd_arg, input, 32, command argument.
REQ-009 SHALL have port crc_start, output, 1, one-cycle start pulse to the CRC7 engine.
REQ-010 SHALL have port crc_data, output, 32, CRC engine operand.
REQ-011 SHALL have port crc_result, input, 8, CRC engine remainder; bits [6:0] are used.
REQ-012 SHALL have port crc_done, input, 1, CRC engine completion pulse.
REQ-013 SHALL have ports sclk, mosi and cs_n, each output, 1, SPI mode-0 command lines.
REQ-014 SHALL have port done, output, 1, one-cycle pulse after the frame is sent.
REQ-015 SHALL have port err, output, 1, one-cycle pulse on CRC timeout.

Function
REQ-016 SHALL implement the FSM IDLE -> CRC_REQ -> CRC_WAIT -> LOAD -> SHIFT -> FIN -> IDLE.
- cmd_ready is 1 only in IDLE.
- A handshake (cmd_valid & cmd_ready) captures cmd_index and cmd_arg and moves to CRC_REQ.
- cmd_valid outside IDLE is ignored.
REQ-017 SHALL drive the CRC engine as follows.
- crc_data = captured cmd_arg, held stable from CRC_REQ until LOAD is left.
- crc_start = 1 for exactly the one CRC_REQ cycle.
- CRC_WAIT stays until crc_done = 1, then latches crc_result[6:0] and goes to LOAD.
REQ-018 SHALL build the frame in LOAD as a 48-bit MSB-first word.
- Layout: {0, 1, cmd_index[5:0], cmd_arg[31:0], crc[6:0], 1}.
- In LOAD: cs_n = 0 and mosi = frame bit 47.
REQ-019 SHALL shift the frame in SHIFT as follows.
- sclk toggles every CLK_DIV clk cycles, starting low.
- mosi advances one bit on each falling sclk edge.
- After the 48th rising edge, the next falling edge ends SHIFT; sclk is then left low.
- Duration is 96*CLK_DIV clk cycles.
REQ-020 SHALL, in FIN, drive cs_n = 1 and mosi = 1, pulse done for 1 cycle, then return to IDLE (cmd_ready = 1 on the next cycle).

Reset
REQ-022 SHALL, whenever rst = 1, override everything and enter IDLE next cycle, including mid-frame and mid-CRC-wait.
- cs_n = 1, sclk = 0, mosi = 1.
- crc_start = 0, done = 0, err = 0.
- crc_data = 0, shift register and counters = 0.
- cmd_ready = 0 during rst, 1 on the first cycle after rst deasserts.
REQ-023 SHALL NOT emit a partial-frame done after reset.

Configuration
REQ-021 SHALL support macro SD_CMD_TX_CRC_TIMEOUT_EN as follows.
- Defined: a counter in CRC_WAIT aborts after TIMEOUT cycles without crc_done, pulsing err for 1 cycle and returning to IDLE with no frame sent (cs_n stays 1).
- Undefined: CRC_WAIT waits indefinitely, err is tied to 0, and no counter is synthesized.

Structure
REQ-024 SHALL put shared definitions in package sd_pkg.
- FSM state encoding.
- SD_FRAME_W = 48.
- SD_START_BIT = 0, SD_TX_BIT = 1, SD_END_BIT = 1.
- CRC7 operand width 32.
REQ-025 SHALL factor the sclk half-period divider into sub-module sd_sclk_gen.
- Outputs: rise_en and fall_en one-cycle strobes.
- sd_sclk_gen is enabled only in SHIFT.

Verification
REQ-026 SHALL pass: CMD0, arg 0x00000000, CRC model returns 0x4A after 10 cycles -> mosi bytes 40 00 00 00 00 95, cs_n low for the whole 48 bits, one done pulse.
REQ-027 SHALL pass: CMD8, arg 0x000001AA, CRC model returns 0x43 -> bytes 48 00 00 01 AA 87.
REQ-028 SHALL pass: CLK_DIV = 1 and CLK_DIV = 4 -> SHIFT lasts 96 and 384 clk cycles respectively, with mosi stable on every rising sclk edge.
REQ-029 SHALL pass: cmd_valid held high during a frame -> the second command is accepted only after done, with no overlap or corruption.
REQ-030 SHALL pass: rst asserted at bit 20 of SHIFT -> next cycle cs_n = 1, sclk = 0, mosi = 1, no done; a following CMD0 is sent correctly.
REQ-031 SHALL pass, with SD_CMD_TX_CRC_TIMEOUT_EN defined and crc_done never asserted -> err pulses at cycle TIMEOUT = 255 of CRC_WAIT, cs_n never falls, and cmd_ready returns.
